// File: rtl/char_phase_decoder_if.sv
// Pad-side link signals and decoded outputs of the phase-encoded 4x4 character receiver.
interface char_phase_decoder_if;
  logic        ref_in;
  logic [15:0] pix_in;
  logic [15:0] frame_pattern;
  logic        frame_stb;
  logic        frame_err;
  logic [1:0]  char_code;
  logic        char_known;
  logic        char_valid;
  logic        ref_lost;

  modport master (
    output ref_in, pix_in,
    input  frame_pattern, frame_stb, frame_err, char_code, char_known, char_valid, ref_lost
  );

  modport slave (
    input  ref_in, pix_in,
    output frame_pattern, frame_stb, frame_err, char_code, char_known, char_valid, ref_lost
  );
endinterface

// File: rtl/char_phase_decoder.sv
// Samples each pixel in both reference phases, rebuilds the 16-bit frame, classifies it
// as A/J/N/X and locks after a run of identical good frames; flags reference loss.
module char_phase_decoder #(
  parameter int unsigned SAMPLE_DLY = 4,
  parameter int unsigned STABLE_CNT = 3,
  parameter int unsigned TIMEOUT_W  = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  char_phase_decoder_if.slave  bus
);

  localparam int unsigned DlyW = $clog2(SAMPLE_DLY + 1);
  localparam int unsigned StW  = $clog2(STABLE_CNT + 1);

  localparam logic [DlyW-1:0]      DlyLoad   = DlyW'(SAMPLE_DLY - 1);
  localparam logic [StW-1:0]       StableMax = StW'(STABLE_CNT);
  localparam logic [StW-1:0]       StableOne = StW'(1);
  localparam logic [TIMEOUT_W-1:0] TmoMax    = '1;
  localparam logic [TIMEOUT_W-1:0] TmoLast   = TmoMax - TIMEOUT_W'(1);

  typedef enum logic [2:0] {StIdle, StDlyH, StWaitFall, StDlyL, StEval} state_e;

  state_e               state_q;
  logic                 ref_s1_q, ref_s2_q, ref_prev_q;
  logic [15:0]          pix_s1_q, pix_s2_q;
  logic [DlyW-1:0]      dly_q;
  logic [15:0]          h_q, l_q;
  logic [TIMEOUT_W-1:0] tmo_q;
  logic [StW-1:0]       stable_q;
  logic                 prev_ok_q;
  logic [15:0]          frame_pattern_q;
  logic                 frame_stb_q, frame_err_q;
  logic [1:0]           char_code_q;
  logic                 char_known_q, char_valid_q, ref_lost_q;

  logic           rise, fall, frame_good, frame_bad;
  logic [StW-1:0] stable_nxt;
  logic [1:0]     code_nxt;
  logic           known_nxt;

  assign rise = ref_s2_q & ~ref_prev_q;
  assign fall = ~ref_s2_q & ref_prev_q;

  // Premature edges abort the frame; in EVAL a pixel with H==L is stuck.
  assign frame_good = (state_q == StEval) && (&(h_q ^ l_q));
  assign frame_bad  = ((state_q == StDlyH) && fall) || ((state_q == StDlyL) && rise) ||
                      ((state_q == StEval) && !(&(h_q ^ l_q)));

  always_comb begin
    stable_nxt = StableOne;
    if (prev_ok_q && (h_q == frame_pattern_q)) begin
      stable_nxt = (stable_q == StableMax) ? StableMax : stable_q + StW'(1);
    end
  end

  always_comb begin
    known_nxt = 1'b1;
    code_nxt  = 2'b00;
    case (h_q)
      16'h9F8F: code_nxt = 2'b00;
      16'h6998: code_nxt = 2'b01;
      16'h9DA9: code_nxt = 2'b10;
      16'h9679: code_nxt = 2'b11;
      default:  known_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      ref_s1_q        <= 1'b0;
      ref_s2_q        <= 1'b0;
      ref_prev_q      <= 1'b0;
      pix_s1_q        <= '0;
      pix_s2_q        <= '0;
      dly_q           <= '0;
      h_q             <= '0;
      l_q             <= '0;
      tmo_q           <= '0;
      stable_q        <= '0;
      prev_ok_q       <= 1'b0;
      frame_pattern_q <= '0;
      frame_stb_q     <= 1'b0;
      frame_err_q     <= 1'b0;
      char_code_q     <= 2'b00;
      char_known_q    <= 1'b0;
      char_valid_q    <= 1'b0;
      ref_lost_q      <= 1'b0;
    end else begin
      ref_s1_q    <= bus.ref_in;
      ref_s2_q    <= ref_s1_q;
      ref_prev_q  <= ref_s2_q;
      pix_s1_q    <= bus.pix_in;
      pix_s2_q    <= pix_s1_q;
      frame_stb_q <= 1'b0;
      frame_err_q <= 1'b0;

      if (rise) begin
        tmo_q      <= '0;
        ref_lost_q <= 1'b0;
      end else if (tmo_q != TmoMax) begin
        tmo_q <= tmo_q + TIMEOUT_W'(1);
      end

      // Counter saturates at TmoMax, so the loss event fires once per outage.
      if (!rise && (tmo_q == TmoLast)) begin
        ref_lost_q   <= 1'b1;
        char_valid_q <= 1'b0;
        stable_q     <= '0;
        state_q      <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) begin
              state_q <= StDlyH;
              dly_q   <= DlyLoad;
            end
          end
          StDlyH: begin
            if (fall) begin
              state_q <= StIdle;
            end else if (dly_q == '0) begin
              h_q     <= pix_s2_q;
              state_q <= StWaitFall;
            end else begin
              dly_q <= dly_q - DlyW'(1);
            end
          end
          StWaitFall: begin
            if (fall) begin
              state_q <= StDlyL;
              dly_q   <= DlyLoad;
            end
          end
          StDlyL: begin
            if (rise) begin
              state_q <= StIdle;
            end else if (dly_q == '0) begin
              l_q     <= pix_s2_q;
              state_q <= StEval;
            end else begin
              dly_q <= dly_q - DlyW'(1);
            end
          end
          StEval:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase

        if (frame_bad) begin
          frame_err_q  <= 1'b1;
          stable_q     <= '0;
          char_valid_q <= 1'b0;
          prev_ok_q    <= 1'b0;
        end else if (frame_good) begin
          frame_pattern_q <= h_q;
          frame_stb_q     <= 1'b1;
          prev_ok_q       <= 1'b1;
          stable_q        <= stable_nxt;
          if (stable_nxt == StableMax) begin
            char_valid_q <= 1'b1;
            char_code_q  <= code_nxt;
            char_known_q <= known_nxt;
          end else begin
            char_valid_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.frame_pattern = frame_pattern_q;
  assign bus.frame_stb     = frame_stb_q;
  assign bus.frame_err     = frame_err_q;
  assign bus.char_code     = char_code_q;
  assign bus.char_known    = char_known_q;
  assign bus.char_valid    = char_valid_q;
  assign bus.ref_lost      = ref_lost_q;

endmodule
